ps2_matrix: RTL and testbench

- Parametrised PS/2 keyboard front-end that maintains an active-low key matrix of ROWS x COLS bits for the host machine's row-scan port.
- Successor to the fixed 10x8 keyboard block. Adds:
  - E0 extended-code and E1 (Pause) prefix handling.
  - Frame timeout recovery.
  - Multi-row scanning, where several rows are selected at once and their columns are ANDed.
  - Matrix flush on keyboard self-test.
- Sits between the board PS/2 pins and the machine core's keyboard read port.

---
 rtl/ps2_matrix_pkg.sv | 105 ++++++++++
 rtl/ps2_keymap.sv | 19 +
 rtl/ps2_matrix.sv | 239 +++++++++++++++++++++++
 tb/tb_ps2_matrix.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_matrix_pkg.sv
// Shared constants, decoder state encoding and the default Lynx scancode map
// for the PS/2 keyboard matrix front-end.
package ps2_matrix_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_AA     = 8'hAA;
  localparam logic [7:0] SC_FA     = 8'hFA;
  localparam logic [7:0] SC_FE     = 8'hFE;
  localparam logic [7:0] SC_00     = 8'h00;
  localparam logic [7:0] SC_FF     = 8'hFF;
  localparam logic [7:0] SC_F11    = 8'h78;
  localparam logic [7:0] SC_F12    = 8'h07;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXT   = 3'd1,
    ST_BRK   = 3'd2,
    ST_EBRK  = 3'd3,
    ST_PAUSE = 3'd4
  } dec_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } km_hit_t;

  function automatic km_hit_t km_at(input logic [3:0] r, input logic [2:0] c);
    return {1'b1, r, c};
  endfunction

  // {ext, code} -> matrix position; anything not listed is unmapped
  function automatic km_hit_t default_keymap(input logic ext, input logic [7:0] code);
    km_hit_t h;
    h = '0;
    case ({ext, code})
      9'h016: h = km_at(4'd0, 3'd0);
      9'h058: h = km_at(4'd0, 3'd3);
      9'h175: h = km_at(4'd0, 3'd4);
      9'h172: h = km_at(4'd0, 3'd5);
      9'h076: h = km_at(4'd0, 3'd6);
      9'h012: h = km_at(4'd0, 3'd7);
      9'h059: h = km_at(4'd0, 3'd7);
      9'h026: h = km_at(4'd1, 3'd0);
      9'h025: h = km_at(4'd1, 3'd1);
      9'h024: h = km_at(4'd1, 3'd2);
      9'h022: h = km_at(4'd1, 3'd3);
      9'h023: h = km_at(4'd1, 3'd4);
      9'h021: h = km_at(4'd1, 3'd5);
      9'h01E: h = km_at(4'd2, 3'd0);
      9'h015: h = km_at(4'd2, 3'd1);
      9'h01D: h = km_at(4'd2, 3'd2);
      9'h01A: h = km_at(4'd2, 3'd3);
      9'h01B: h = km_at(4'd2, 3'd4);
      9'h01C: h = km_at(4'd2, 3'd5);
      9'h014: h = km_at(4'd2, 3'd6);
      9'h114: h = km_at(4'd2, 3'd6);
      9'h02E: h = km_at(4'd3, 3'd0);
      9'h02D: h = km_at(4'd3, 3'd1);
      9'h02C: h = km_at(4'd3, 3'd2);
      9'h02A: h = km_at(4'd3, 3'd3);
      9'h02B: h = km_at(4'd3, 3'd4);
      9'h032: h = km_at(4'd3, 3'd5);
      9'h036: h = km_at(4'd4, 3'd0);
      9'h035: h = km_at(4'd4, 3'd1);
      9'h033: h = km_at(4'd4, 3'd2);
      9'h029: h = km_at(4'd4, 3'd3);
      9'h034: h = km_at(4'd4, 3'd4);
      9'h031: h = km_at(4'd4, 3'd5);
      9'h03D: h = km_at(4'd5, 3'd0);
      9'h03E: h = km_at(4'd5, 3'd1);
      9'h03C: h = km_at(4'd5, 3'd2);
      9'h03A: h = km_at(4'd5, 3'd3);
      9'h03B: h = km_at(4'd5, 3'd5);
      9'h046: h = km_at(4'd6, 3'd0);
      9'h043: h = km_at(4'd6, 3'd1);
      9'h044: h = km_at(4'd6, 3'd2);
      9'h041: h = km_at(4'd6, 3'd3);
      9'h042: h = km_at(4'd6, 3'd5);
      9'h045: h = km_at(4'd7, 3'd0);
      9'h04D: h = km_at(4'd7, 3'd1);
      9'h04B: h = km_at(4'd7, 3'd2);
      9'h049: h = km_at(4'd7, 3'd3);
      9'h04C: h = km_at(4'd7, 3'd5);
      9'h04E: h = km_at(4'd8, 3'd0);
      9'h054: h = km_at(4'd8, 3'd1);
      9'h052: h = km_at(4'd8, 3'd2);
      9'h04A: h = km_at(4'd8, 3'd3);
      9'h05B: h = km_at(4'd8, 3'd5);
      9'h066: h = km_at(4'd9, 3'd0);
      9'h171: h = km_at(4'd9, 3'd0);
      9'h16B: h = km_at(4'd9, 3'd2);
      9'h05A: h = km_at(4'd9, 3'd3);
      9'h174: h = km_at(4'd9, 3'd5);
      default: h = '0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scancode lookup; swap this module to retarget another machine.
module ps2_keymap
  import ps2_matrix_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output logic       valid_o,
  output logic [3:0] row_o,
  output logic [2:0] col_o
);

  km_hit_t hit_s;

  assign hit_s   = default_keymap(ext_i, code_i);
  assign valid_o = hit_s.valid;
  assign row_o   = hit_s.row;
  assign col_o   = hit_s.col;

endmodule

// File: rtl/ps2_matrix.sv
// PS/2 keyboard front-end: glitch filter, frame receiver with timeout,
// prefix decoder and an active-low ROWS x COLS key matrix read by row mask.
module ps2_matrix
  import ps2_matrix_pkg::*;
#(
  parameter int ROWS    = 10,
  parameter int COLS    = 8,
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            ce_i,
  input  logic [1:0]      ps2_i,
  input  logic [ROWS-1:0] row_i,
  output logic [COLS-1:0] do_o,
  output logic            boot_o,
  output logic            reset_key_o,
  output logic            frame_err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [FILTER-1:0] filt_q;
  logic              clk_f_q;
  logic              data_q;
  logic              fall_s;

  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic              par_ok_q, par_ok_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;

  dec_state_e        state_q, state_d;
  logic [2:0]        skip_q, skip_d;
  logic              byte_stb_s, upd_s, brk_s, ext_s, flush_s;

  logic              km_valid_s;
  logic [3:0]        km_row_s;
  logic [2:0]        km_col_s;

  logic [COLS-1:0]   key_q [ROWS];
  logic              boot_q, rkey_q;

  // Filtered clock only changes after FILTER identical samples
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      filt_q  <= '1;
      clk_f_q <= 1'b1;
    end else if (ce_i) begin
      filt_q <= {filt_q[FILTER-2:0], ps2_i[0]};
      if (&filt_q) begin
        clk_f_q <= 1'b1;
      end else if (~|filt_q) begin
        clk_f_q <= 1'b0;
      end else begin
        clk_f_q <= clk_f_q;
      end
    end
  end

  // Data line sample and frame payload are not part of the reset domain
  always_ff @(posedge clock_i) begin
    if (ce_i) begin
      data_q   <= ps2_i[1];
      sh_q     <= sh_d;
      par_ok_q <= par_ok_d;
      skip_q   <= skip_d;
    end
  end

  assign fall_s = ce_i & clk_f_q & ~(|filt_q);

  // Frame receiver: start, 8 data LSB first, odd parity, stop; plus timeout
  always_comb begin
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    par_ok_d = par_ok_q;
    tmo_d    = tmo_q;
    rdy_d    = 1'b0;
    err_d    = 1'b0;
    if (fall_s) begin
      tmo_d = '0;
      case (cnt_q)
        4'd0: begin
          if (!data_q) cnt_d = 4'd1;
          else         cnt_d = 4'd0;
        end
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          sh_d  = {data_q, sh_q[7:1]};
          cnt_d = cnt_q + 4'd1;
        end
        4'd9: begin
          par_ok_d = ^{sh_q, data_q};
          cnt_d    = 4'd10;
        end
        4'd10: begin
          cnt_d = 4'd0;
          if (data_q && par_ok_q) rdy_d = 1'b1;
          else                    err_d = 1'b1;
        end
        default: cnt_d = 4'd0;
      endcase
    end else if (cnt_q != 4'd0) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        cnt_d = 4'd0;
        tmo_d = '0;
        err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Receiver control registers
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= 4'd0;
      tmo_q <= '0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else if (ce_i) begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
    end
  end

  assign byte_stb_s = ce_i & rdy_q;

  // Prefix decoder: turns the byte stream into make/break/flush commands
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    upd_s   = 1'b0;
    brk_s   = 1'b0;
    ext_s   = 1'b0;
    flush_s = 1'b0;
    if (byte_stb_s) begin
      case (state_q)
        ST_IDLE: begin
          case (sh_q)
            SC_E0: state_d = ST_EXT;
            SC_F0: state_d = ST_BRK;
            SC_E1: begin
              state_d = ST_PAUSE;
              skip_d  = PAUSE_SKIP;
            end
            SC_AA: flush_s = 1'b1;
            SC_FA, SC_FE, SC_00, SC_FF: state_d = ST_IDLE;
            default: upd_s = 1'b1;
          endcase
        end
        ST_EXT: begin
          ext_s = 1'b1;
          if (sh_q == SC_F0) begin
            state_d = ST_EBRK;
          end else begin
            state_d = ST_IDLE;
            upd_s   = (sh_q != SC_LSHIFT) && (sh_q != SC_RSHIFT);
          end
        end
        ST_BRK: begin
          upd_s   = 1'b1;
          brk_s   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EBRK: begin
          upd_s   = 1'b1;
          brk_s   = 1'b1;
          ext_s   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
          else                state_d = ST_PAUSE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Decoder state register
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else if (ce_i) state_q <= state_d;
  end

  ps2_keymap u_keymap (
    .ext_i   (ext_s),
    .code_i  (sh_q),
    .valid_o (km_valid_s),
    .row_o   (km_row_s),
    .col_o   (km_col_s)
  );

  // Key matrix; positions outside ROWS x COLS never match and are dropped
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int r = 0; r < ROWS; r++) key_q[r] <= '1;
    end else if (flush_s) begin
      for (int r = 0; r < ROWS; r++) key_q[r] <= '1;
    end else if (upd_s && km_valid_s) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (km_row_s == 4'(r) && km_col_s == 3'(c)) key_q[r][c] <= brk_s;
    end
  end

  // F11/F12 are side-band keys, not matrix positions
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      boot_q <= 1'b1;
      rkey_q <= 1'b1;
    end else if (upd_s && !ext_s) begin
      if (sh_q == SC_F11) boot_q <= brk_s;
      if (sh_q == SC_F12) rkey_q <= brk_s;
    end
  end

  // Read port: AND of every selected (low) row, all ones when none selected
  always_comb begin
    do_o = '1;
    for (int r = 0; r < ROWS; r++) do_o = do_o & (key_q[r] | {COLS{row_i[r]}});
  end

  assign boot_o      = boot_q;
  assign reset_key_o = rkey_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_ps2_matrix.sv
// Scoreboard bench for ps2_matrix: stimulus queues expected output events,
// a monitor pops one per observed output change or frame_err pulse.
module tb_ps2_matrix;

  localparam int ROWS    = 10;
  localparam int COLS    = 8;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 4095;
  localparam int HALF    = 30;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ce = 1'b1;
  logic [1:0]      ps2 = 2'b11;
  logic [ROWS-1:0] row = '1;
  logic [COLS-1:0] do_w;
  logic            boot_w, rk_w, ferr_w;

  always #5 clk = ~clk;

  ps2_matrix #(.ROWS(ROWS), .COLS(COLS), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock_i     (clk),
    .reset_i     (rst_n),
    .ce_i        (ce),
    .ps2_i       (ps2),
    .row_i       (row),
    .do_o        (do_w),
    .boot_o      (boot_w),
    .reset_key_o (rk_w),
    .frame_err_o (ferr_w)
  );

  typedef struct {
    bit         is_err;
    logic [9:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_data(input string nm, input logic [7:0] d, input logic b, input logic r);
    exp_t e;
    e.is_err = 1'b0;
    e.val    = {d, b, r};
    e.name   = nm;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input string nm);
    exp_t e;
    e.is_err = 1'b1;
    e.val    = 10'h000;
    e.name   = nm;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2[1] = b;
    tick(HALF);
    ps2[0] = 1'b0;
    tick(HALF);
    ps2[0] = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(bad_stop ? 1'b0 : 1'b1);
    ps2[1] = 1'b1;
    tick(40);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b0);
  endtask

  task automatic check_evt(input bit is_err, input logic [9:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: got do=%h boot=%b reset_key=%b, required no event",
               is_err ? "frame_err" : "output", obs[9:2], obs[1], obs[0]);
    end else begin
      e = exp_q.pop_front();
      if (e.is_err != is_err || (!is_err && obs !== e.val)) begin
        n_bad++;
        $display("FAIL %s: got %s do=%h boot=%b reset_key=%b, required %s do=%h boot=%b reset_key=%b",
                 e.name, is_err ? "frame_err" : "output", obs[9:2], obs[1], obs[0],
                 e.is_err ? "frame_err" : "output", e.val[9:2], e.val[1], e.val[0]);
      end
    end
  endtask

  initial begin : monitor
    logic [9:0] prev, obs;
    logic       prev_err;
    prev     = '0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      obs = {do_w, boot_w, rk_w};
      if (ferr_w && !prev_err) check_evt(1'b1, obs);
      if (obs !== prev) check_evt(1'b0, obs);
      prev     = obs;
      prev_err = ferr_w;
    end
  end

  initial begin : stimulus
    rst_n = 1'b1;
    expect_data("reset_state", 8'hFF, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(20);

    row = 10'h3FB;
    expect_data("a_make", 8'hDF, 1'b1, 1'b1);
    send(8'h1C);
    expect_data("a_break", 8'hFF, 1'b1, 1'b1);
    send(8'hF0); send(8'h1C);

    row = 10'h3FE;
    expect_data("up_make", 8'hEF, 1'b1, 1'b1);
    send(8'hE0); send(8'h75);
    expect_data("up_break", 8'hFF, 1'b1, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h75);

    expect_err("bad_parity");
    send_byte(8'h16, 1'b1, 1'b0);
    expect_data("one_make", 8'hFE, 1'b1, 1'b1);
    send(8'h16);
    expect_data("one_break", 8'hFF, 1'b1, 1'b1);
    send(8'hF0); send(8'h16);

    row = 10'h3FB;
    expect_err("timeout");
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    ps2[1] = 1'b1;
    tick(TIMEOUT + 100);
    expect_data("two_after_timeout", 8'hFE, 1'b1, 1'b1);
    send(8'h1E);
    expect_data("two_break", 8'hFF, 1'b1, 1'b1);
    send(8'hF0); send(8'h1E);

    expect_data("a_make_row2", 8'hDF, 1'b1, 1'b1);
    send(8'h1C);
    send(8'h26);
    expect_data("multi_row", 8'hDE, 1'b1, 1'b1);
    row = 10'h3F9;
    tick(5);
    expect_data("self_test_flush", 8'hFF, 1'b1, 1'b1);
    send(8'hAA);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_data("a_after_pause", 8'hDF, 1'b1, 1'b1);
    send(8'h1C);
    expect_data("f12_make", 8'hDF, 1'b1, 1'b0);
    send(8'h07);
    expect_data("f11_make", 8'hDF, 1'b0, 1'b0);
    send(8'h78);
    expect_data("f12_break", 8'hDF, 1'b0, 1'b1);
    send(8'hF0); send(8'h07);

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    expect_data("async_reset", 8'hFF, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (do_w !== 8'hFF || boot_w !== 1'b1 || rk_w !== 1'b1 || ferr_w !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_immediate: got do=%h boot=%b reset_key=%b frame_err=%b, required FF 1 1 0",
               do_w, boot_w, rk_w, ferr_w);
    end
    ps2[1] = 1'b1;
    tick(10);
    rst_n = 1'b1;
    tick(20);
    expect_data("a_after_reset", 8'hDF, 1'b1, 1'b1);
    send(8'h1C);
    expect_err("bad_stop");
    send_byte(8'h1B, 1'b0, 1'b1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    tick(200);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no event, required %s do=%h boot=%b reset_key=%b",
               e.name, e.is_err ? "frame_err" : "output", e.val[9:2], e.val[1], e.val[0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
